// File: rtl/run_pkg.sv
// run_pkg: shared definitions for the running-man game slice.
//   - FSM state encoding for run_draw_ctrl
//   - screen geometry, floor rows and colour constants used by the datapath
package run_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;

  localparam int FLOOR_ROW0  = 35;
  localparam int FLOOR_ROW1  = 75;
  localparam int FLOOR_ROW2  = 115;
  localparam int FLOOR_THICK = 5;

  localparam logic [2:0] COL_FLOOR = 3'b101;
  localparam logic [2:0] COL_MAN   = 3'b111;
  localparam logic [2:0] COL_BG    = 3'b000;

  typedef logic [2:0] state_t;

  localparam state_t S_FLOORS_REQ = 3'd0;
  localparam state_t S_GAP        = 3'd1;
  localparam state_t S_DRAW_REQ   = 3'd2;
  localparam state_t S_WAIT_FRAME = 3'd3;
  localparam state_t S_ERASE_REQ  = 3'd4;
  localparam state_t S_UPDATE     = 3'd5;
  localparam state_t S_LOAD       = 3'd6;

  function automatic logic is_req_state(input state_t s);
    return (s == S_FLOORS_REQ) || (s == S_DRAW_REQ) || (s == S_ERASE_REQ);
  endfunction

endpackage

// File: rtl/run_frame_timer.sv
// run_frame_timer: cycle counter that runs 0..TICKS-1 and parks at terminal.
// Used both as the animation frame pacer and as the handshake watchdog.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   clr           synchronous return to 0 (wins over en)
//   en            advance by one per cycle while below terminal
//   tick          high while the count sits at TICKS-1
module run_frame_timer #(
  parameter int TICKS = 833333,
  parameter int W     = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [W-1:0] TERM = W'(TICKS - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TERM)) begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == TERM);

endmodule

// File: rtl/run_draw_ctrl.sv
// run_draw_ctrl: initiator-side control FSM for the running-man datapath.
// Draws the floors once, then loops draw man / wait frame / erase / update /
// load, computing the jump arc and crouch pose between frames.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   jump_btn, crouch_btn, pause  player controls (synchronous levels)
//   *_finish                     datapath completion levels
//   drawing_floors/draw_man/erase  request outputs, plot = any request
//   ld_x/ld_y, x_in/y_in         load next man origin into datapath
//   normal1crouch0, airborne     pose and jump status
//   timeout_err                  sticky: a finish never arrived
//
// state         | meaning
// S_FLOORS_REQ  | request floor draw (once per reset)
// S_GAP         | 1 idle cycle between requests
// S_DRAW_REQ    | request man draw
// S_WAIT_FRAME  | pace the frame; held at terminal while paused
// S_ERASE_REQ   | request man erase (old pose/position)
// S_UPDATE      | compute next pose and position
// S_LOAD        | pulse ld_x/ld_y with the new origin
module run_draw_ctrl
  import run_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int JUMP_H      = 12,
  parameter int MAN_X       = 30,
  parameter int GROUND_Y    = 108,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       jump_btn,
  input  logic       crouch_btn,
  input  logic       pause,
  input  logic       draw_floors_finish,
  input  logic       draw_man_finish,
  input  logic       erase_finish,
  output logic       drawing_floors,
  output logic       draw_man,
  output logic       erase,
  output logic       plot,
  output logic       ld_x,
  output logic       ld_y,
  output logic [7:0] x_in,
  output logic [6:0] y_in,
  output logic       normal1crouch0,
  output logic       airborne,
  output logic       timeout_err
);

  if ((JUMP_H < 1) || (JUMP_H > GROUND_Y) || (GROUND_Y > 127) || (MAN_X > 255)) begin : g_param_chk
    $error("run_draw_ctrl: bad JUMP_H/GROUND_Y/MAN_X");
  end

  localparam logic [7:0] MAN_X_C    = 8'(MAN_X);
  localparam logic [6:0] GROUND_Y_C = 7'(GROUND_Y);
  localparam logic [6:0] JUMP_H_C   = 7'(JUMP_H);

  state_t     state, state_nxt;
  logic       in_req, in_req_d;
  logic       fin_sel, fin_ok, wd_tick, fr_tick;
  logic       req_done, timeout_set;
  logic [6:0] offset, off_nxt;
  logic       falling, fall_nxt, air_nxt;

  // Requests are registered from state_nxt, so the request output (not the
  // state) marks the live handshake window; in_req_d masks its first cycle.
  assign in_req = drawing_floors | draw_man | erase;

  run_frame_timer #(.TICKS(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~in_req),
    .en      (1'b1),
    .tick    (wd_tick)
  );

  run_frame_timer #(.TICKS(FRAME_TICKS)) u_frame (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state != S_WAIT_FRAME),
    .en      (1'b1),
    .tick    (fr_tick)
  );

  always_comb begin
    fin_sel = 1'b0;
    case (state)
      S_FLOORS_REQ: fin_sel = draw_floors_finish;
      S_DRAW_REQ:   fin_sel = draw_man_finish;
      S_ERASE_REQ:  fin_sel = erase_finish;
      default:      fin_sel = 1'b0;
    endcase
  end

  assign fin_ok      = in_req & in_req_d & fin_sel;
  assign req_done    = fin_ok | (in_req & wd_tick);
  assign timeout_set = in_req & wd_tick & ~fin_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FLOORS_REQ: if (req_done) state_nxt = S_GAP;
      S_GAP:        state_nxt = S_DRAW_REQ;
      S_DRAW_REQ:   if (req_done) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: if (fr_tick && !pause) state_nxt = S_ERASE_REQ;
      S_ERASE_REQ:  if (req_done) state_nxt = S_UPDATE;
      S_UPDATE:     state_nxt = S_LOAD;
      S_LOAD:       state_nxt = S_GAP;
      default:      state_nxt = S_FLOORS_REQ;
    endcase
  end

  // Jump arc: launch takes the first rise step in the same update, so the
  // man leaves the ground on the very next drawn frame.
  always_comb begin
    off_nxt  = offset;
    air_nxt  = airborne;
    fall_nxt = falling;
    if (!airborne) begin
      if (jump_btn) begin
        air_nxt  = 1'b1;
        off_nxt  = 7'd1;
        fall_nxt = (JUMP_H_C == 7'd1);
      end
    end else if (!falling) begin
      off_nxt = offset + 7'd1;
      if (off_nxt == JUMP_H_C) fall_nxt = 1'b1;
    end else begin
      off_nxt = offset - 7'd1;
      if (off_nxt == 7'd0) air_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_FLOORS_REQ;
      in_req_d       <= 1'b0;
      drawing_floors <= 1'b0;
      draw_man       <= 1'b0;
      erase          <= 1'b0;
      plot           <= 1'b0;
      ld_x           <= 1'b0;
      ld_y           <= 1'b0;
      x_in           <= MAN_X_C;
      y_in           <= GROUND_Y_C;
      normal1crouch0 <= 1'b1;
      airborne       <= 1'b0;
      falling        <= 1'b0;
      offset         <= 7'd0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      in_req_d       <= in_req;
      drawing_floors <= (state_nxt == S_FLOORS_REQ);
      draw_man       <= (state_nxt == S_DRAW_REQ);
      erase          <= (state_nxt == S_ERASE_REQ);
      plot           <= is_req_state(state_nxt);
      ld_x           <= (state_nxt == S_LOAD);
      ld_y           <= (state_nxt == S_LOAD);
      x_in           <= MAN_X_C;
      if (timeout_set) timeout_err <= 1'b1;
      // Pose/position move only here, after the erase used the old ones.
      if (state == S_UPDATE) begin
        offset         <= off_nxt;
        airborne       <= air_nxt;
        falling        <= fall_nxt;
        y_in           <= GROUND_Y_C - off_nxt;
        normal1crouch0 <= ~(crouch_btn & ~air_nxt);
      end
    end
  end

endmodule

// File: tb/tb_run_draw_ctrl.sv
module tb_run_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       jump_btn = 1'b0, crouch_btn = 1'b0, pause = 1'b0;
  logic       draw_floors_finish = 1'b0, draw_man_finish = 1'b0, erase_finish = 1'b0;
  logic       drawing_floors, draw_man, erase, plot, ld_x, ld_y;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic       normal1crouch0, airborne, timeout_err;

  run_draw_ctrl #(
    .FRAME_TICKS (10),
    .JUMP_H      (3),
    .MAN_X       (30),
    .GROUND_Y    (108),
    .TIMEOUT     (16)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .jump_btn           (jump_btn),
    .crouch_btn         (crouch_btn),
    .pause              (pause),
    .draw_floors_finish (draw_floors_finish),
    .draw_man_finish    (draw_man_finish),
    .erase_finish       (erase_finish),
    .drawing_floors     (drawing_floors),
    .draw_man           (draw_man),
    .erase              (erase),
    .plot               (plot),
    .ld_x               (ld_x),
    .ld_y               (ld_y),
    .x_in               (x_in),
    .y_in               (y_in),
    .normal1crouch0     (normal1crouch0),
    .airborne           (airborne),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  typedef struct packed {
    logic [6:0] y;
    logic       air;
    logic       pose;
  } exp_t;
  exp_t sb_q[$];

  // Responder: finish rises on the lat-th request cycle; lat 0 = never.
  int  fl_lat = 3, man_lat = 3, er_lat = 3;
  bit  man_stale = 1'b0;
  int  fl_c = 0, man_c = 0, er_c = 0;

  always @(negedge clk) begin
    fl_c  = drawing_floors ? fl_c + 1 : 0;
    man_c = draw_man ? man_c + 1 : 0;
    er_c  = erase ? er_c + 1 : 0;
    draw_floors_finish = (fl_lat != 0) && (fl_c >= fl_lat);
    draw_man_finish    = man_stale || ((man_lat != 0) && (man_c >= man_lat));
    erase_finish       = (er_lat != 0) && (er_c >= er_lat);
  end

  // Monitor: request run lengths, gap after floors, scoreboard on ld pulses.
  bit p_fl = 0, p_man = 0, p_er = 0, p_ld = 0, gap_trk = 0;
  int fl_run = 0, man_run = 0, er_run = 0, gap_run = 0;
  int fl_len = 0, man_len = 0, er_len = 0, gap_len = 0, fl_rises = 0;
  exp_t e;

  always @(negedge clk) begin
    if (drawing_floors) begin
      if (!p_fl) begin fl_rises++; chk("plot_floors", plot, 1); end
      fl_run++;
    end else begin
      if (p_fl) begin fl_len = fl_run; gap_run = 0; gap_trk = 1; end
      fl_run = 0;
    end
    if (gap_trk) begin
      if (draw_man) begin gap_len = gap_run; gap_trk = 0; end
      else gap_run++;
    end
    if (draw_man) begin
      if (!p_man) chk("plot_man", plot, 1);
      man_run++;
    end else begin
      if (p_man) man_len = man_run;
      man_run = 0;
    end
    if (erase) begin
      if (!p_er) chk("plot_erase", plot, 1);
      er_run++;
    end else begin
      if (p_er) er_len = er_run;
      er_run = 0;
    end
    if (ld_x) begin
      chk("sb_depth", sb_q.size() > 0, 1);
      chk("ld_y", ld_y, 1);
      chk("x_in", x_in, 30);
      chk("plot_ld", plot, 0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("y_in", y_in, e.y);
        chk("airborne", airborne, e.air);
        chk("pose", normal1crouch0, e.pose);
      end
    end
    if (p_ld) chk("ld_pulse", ld_x, 0);
    p_fl = drawing_floors; p_man = draw_man; p_er = erase; p_ld = ld_x;
  end

  function automatic logic sel(input int w);
    case (w)
      0:       return drawing_floors;
      1:       return draw_man;
      2:       return erase;
      default: return ld_x;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl, input string tag);
    int n = 0;
    @(negedge clk);
    while (sel(which) !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk(tag, sel(which), lvl);
  endtask

  // Called on the negedge of the S_UPDATE cycle (first cycle after erase).
  task automatic load_check(input logic j, input logic c, input logic [6:0] y,
                            input logic air, input logic pose);
    jump_btn   = j;
    crouch_btn = c;
    sb_q.push_back(exp_t'{y, air, pose});
    @(negedge clk);
    jump_btn = 1'b0;
  endtask

  task automatic do_frame(input logic j, input logic c, input logic [6:0] y,
                          input logic air, input logic pose);
    wait_for(2, 1'b1, "wait_erase_hi");
    wait_for(2, 1'b0, "wait_erase_lo");
    load_check(j, c, y, air, pose);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_floors"}, drawing_floors, 0);
    chk({pfx, "_draw"}, draw_man, 0);
    chk({pfx, "_erase"}, erase, 0);
    chk({pfx, "_plot"}, plot, 0);
    chk({pfx, "_ldx"}, ld_x, 0);
    chk({pfx, "_ldy"}, ld_y, 0);
    chk({pfx, "_x"}, x_in, 30);
    chk({pfx, "_y"}, y_in, 108);
    chk({pfx, "_pose"}, normal1crouch0, 1);
    chk({pfx, "_air"}, airborne, 0);
    chk({pfx, "_terr"}, timeout_err, 0);
  endtask

  localparam logic [6:0] JUMP_Y [6]   = '{107, 106, 105, 106, 107, 108};
  localparam logic       JUMP_AIR [6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Floors 3 cycles, one gap cycle, then draw_man.
    wait_for(1, 1'b1, "wait_first_draw");
    @(negedge clk);
    chk("floors_len", fl_len, 3);
    chk("gap_len", gap_len, 1);
    chk("man_len", man_len, 0);
    wait_for(1, 1'b0, "wait_first_draw_lo");
    @(negedge clk);
    chk("man_len", man_len, 3);

    do_frame(0, 0, 108, 0, 1);

    // Jump arc, JUMP_H=3.
    for (int i = 0; i < 6; i++)
      do_frame(i == 0, 0, JUMP_Y[i], JUMP_AIR[i], 1);
    chk("floors_once", fl_rises, 1);

    // Crouch on ground, then crouch+jump: jump wins, pose stays standing.
    do_frame(0, 1, 108, 0, 0);
    for (int i = 0; i < 6; i++)
      do_frame(i == 0, 1, JUMP_Y[i], JUMP_AIR[i], JUMP_AIR[i]);
    do_frame(0, 0, 108, 0, 1);

    // Stale draw_man_finish held high: first request cycle masked.
    man_stale = 1'b1;
    wait_for(1, 1'b1, "wait_stale_draw");
    wait_for(1, 1'b0, "wait_stale_draw_lo");
    @(negedge clk);
    chk("stale_man_len", man_len, 2);
    do_frame(0, 0, 108, 0, 1);
    chk("erase_len_stale", er_len, 3);
    man_stale = 1'b0;

    // Pause in S_WAIT_FRAME.
    wait_for(1, 1'b1, "wait_pause_draw");
    wait_for(1, 1'b0, "wait_pause_draw_lo");
    pause = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (erase) cnt++;
    end
    chk("pause_no_erase", cnt, 0);
    pause = 1'b0;
    @(negedge clk);
    chk("erase_after_pause", erase, 1);
    do_frame(0, 0, 108, 0, 1);

    // Erase never finishes: watchdog after 16 request cycles.
    er_lat = 0;
    wait_for(2, 1'b1, "wait_to_erase");
    chk("terr_before", timeout_err, 0);
    cnt = 1;
    while (cnt < 200) begin
      @(negedge clk);
      if (!erase) break;
      cnt++;
    end
    chk("timeout_erase_len", cnt, 16);
    chk("timeout_err_set", timeout_err, 1);
    er_lat = 3;
    load_check(0, 0, 108, 0, 1);
    do_frame(1, 0, 107, 1, 1);
    chk("timeout_err_sticky", timeout_err, 1);

    // Reset mid-erase while airborne with timeout_err set.
    wait_for(2, 1'b1, "wait_rst_erase");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    wait_for(0, 1'b1, "wait_floors2");
    wait_for(1, 1'b1, "wait_draw2");
    @(negedge clk);
    chk("floors_redrawn", fl_rises, 2);
    chk("floors_len2", fl_len, 3);
    chk("gap_len2", gap_len, 1);
    chk("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/run_draw_ctrl.md
Name: run_draw_ctrl

Overview:
- Initiator-side control FSM for the running-man pixel datapath.
- Issues draw_floors / draw_man / erase requests, waits for the matching finish responses, and paces one animation frame per FRAME_TICKS.
- Computes the man's next position (jump arc, crouch pose) and loads it into the datapath via x_in/y_in with ld_x/ld_y.
- Drives plot (VGA adapter write enable) while any draw or erase request is active.

Parameters:
- FRAME_TICKS, 833333, clk cycles per animation frame (60 Hz at 50 MHz).
- JUMP_H, 12, jump apex height in pixels; rise then fall at 1 px/frame.
- MAN_X, 30, fixed man x origin (8 bit).
- GROUND_Y, 108, man y origin when standing on bottom floor (7 bit).
- TIMEOUT, 4096, max cycles to wait for any finish response.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- jump_btn  in  1  synchronous level; request jump
- crouch_btn  in  1  synchronous level; crouch while held
- pause  in  1  hold animation in current frame
- draw_floors_finish  in  1  datapath response, level
- draw_man_finish  in  1  datapath response, level
- erase_finish  in  1  datapath response, level
- drawing_floors  out  1  floor draw request
- draw_man  out  1  man draw request
- erase  out  1  man erase request
- plot  out  1  VGA write enable
- ld_x  out  1  load x_in into datapath origin
- ld_y  out  1  load y_in into datapath origin
- x_in  out  8  next man x origin
- y_in  out  7  next man y origin
- normal1crouch0  out  1  pose select: 1 = standing, 0 = crouch
- airborne  out  1  jump in progress
- timeout_err  out  1  sticky; a finish response never arrived

Behaviour:
- Reset (async, any state, including mid-request): all requests, plot, ld_x, ld_y, airborne and timeout_err are 0; x_in=MAN_X; y_in=GROUND_Y; normal1crouch0=1; state=S_FLOORS_REQ; frame counter=0; jump offset=0, phase=rise.
- States, all outputs registered:
  - S_FLOORS_REQ: drawing_floors=1, plot=1. Go to S_GAP when draw_floors_finish=1.
  - S_GAP: all requests 0 for exactly 1 cycle, so the datapath's sticky finish levels are never mistaken for a new response. Next state is S_DRAW_REQ.
  - S_DRAW_REQ: draw_man=1, plot=1. Go to S_WAIT_FRAME on draw_man_finish=1.
  - S_WAIT_FRAME: frame counter counts 0..FRAME_TICKS-1. At terminal count, if pause=0, go to S_ERASE_REQ. If pause=1, the counter holds at terminal and the state is held.
  - S_ERASE_REQ: erase=1, plot=1. Go to S_UPDATE on erase_finish=1.
  - S_UPDATE (1 cycle): compute the next pose and position, then go to S_LOAD.
  - S_LOAD (1 cycle): ld_x=ld_y=1 with new x_in/y_in; return to S_GAP, then S_DRAW_REQ.
- The floor draw happens once per reset only.
- Request/finish handshake:
  - A request is held high until its finish is sampled 1.
  - A finish input that is 1 on the first request cycle is ignored; only a finish sampled from the 2nd request cycle onward counts. This masks stale sticky levels.
  - Only the finish matching the active request is honoured; others are ignored.
- Timeout:
  - A watchdog counts cycles in each *_REQ state.
  - On reaching TIMEOUT, set timeout_err (sticky until reset) and advance as if finish had arrived.
- Update rules (S_UPDATE), with offset 0..JUMP_H:
  - Not airborne and jump_btn=1: airborne=1, phase=rise.
  - Airborne, rise: offset+1; on reaching JUMP_H, phase=fall.
  - Airborne, fall: offset-1; on reaching 0, airborne=0.
  - y_in = GROUND_Y - offset, 7-bit unsigned. JUMP_H ≤ GROUND_Y is guaranteed by parameter check.
  - normal1crouch0 = ~(crouch_btn & ~airborne). Crouch is ignored while airborne, and jump has priority when both buttons are pressed on the ground.
  - x_in constant = MAN_X.
- Erase always uses the pose and position that were drawn. normal1crouch0 changes only in S_UPDATE, after erase completes.
- Latency, ideal datapath with finish on the 2nd request cycle: frame period = FRAME_TICKS + erase + 2 + gap + draw cycles.

Decomposition:
- Shared package run_pkg:
  - state enum;
  - SCREEN_W=160, SCREEN_H=120;
  - floor rows 35/75/115 and FLOOR_THICK=5;
  - colour constants: floor 3'b101, man 3'b111, background 3'b000.
- One sub-module: run_frame_timer. It contains the frame counter with enable, hold-at-terminal and tick output, and is reused for the watchdog.

Test Plan:
- Reset then ideal responder (finish after 3 cycles), FRAME_TICKS=10 → drawing_floors high exactly 3 cycles, 1 gap cycle, then draw_man; floors never re-requested.
- Stale finish: draw_man_finish held 1 from before request → ignored on 1st cycle; request cycle count ≥2; no skipped draw.
- jump_btn pulsed one cycle, JUMP_H=3 → y_in sequence over frames 107,106,105,106,107,108; airborne falls on the 108 frame; ld_x/ld_y one-cycle pulses each frame.
- crouch_btn held on ground → normal1crouch0=0 at next S_UPDATE. crouch_btn+jump_btn together → jump starts, normal1crouch0 stays 1.
- Responder never asserts erase_finish, TIMEOUT=16 → timeout_err=1 after 16 cycles; FSM proceeds to S_UPDATE; flag stays set.
- pause=1 during S_WAIT_FRAME → no erase issued while high; erase starts 1 cycle after pause drops. reset_n low mid-erase → all outputs to reset values immediately; floors redrawn after release.
